gray_bin_pipe: RTL and testbench

//  Parametrised, pipelined, bidirectional Gray<->binary converter with valid/ready flow control.

---
 rtl/gray_bin_pipe.sv | 228 ++++++++++++++++++++++
 tb/tb_gray_bin_pipe.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_bin_pipe.sv
// -----------------------------------------------------------------------------
// gray_bin_pipe
//
// Pipelined, bidirectional Gray <-> binary converter with valid/ready flow
// control. Each beat carries its own mode bit, so the direction can change
// from one beat to the next with no bubble:
//   in_mode = 0 : Gray -> binary, out[i] = ^(d >> i)   (prefix XOR from the MSB)
//   in_mode = 1 : binary -> Gray, out    = d ^ (d >> 1)
//
// The Gray->binary prefix chain is the long path. It is split MSB-first over
// STAGES register stages, and each stage resolves CHUNK = ceil(N/STAGES) bits.
// A stage's word is partly converted: bits above its window are already
// binary and bits below it are still Gray. Binary->Gray is finished in stage 0
// and later stages pass it through unchanged.
//
// Optional feature (macro GRAY_SEQ_CHECK_EN):
//   Checks the sequence of accepted Gray->binary beats. A beat is flagged
//   (out_err=1 alongside that beat's result) when a previous G2B beat exists
//   and the two Gray codes differ in more than one bit. Repeated values are
//   legal, so a stalled pointer does not raise an error. Binary->Gray beats
//   neither flag nor update the history. When the macro is not defined the
//   checker is not built and out_err is always 0.
//
// Parameters
//   N       data width in bits, >= 2
//   STAGES  pipeline register stages, 1..N
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset; clears all stage state
//   in_valid   in   input beat valid
//   in_ready   out  block accepts a beat this cycle
//   in_mode    in   0 = Gray->binary, 1 = binary->Gray
//   in_data    in   value to convert (N bits)
//   out_valid  out  result valid
//   out_ready  in   downstream accepts the result
//   out_mode   out  mode of the beat being presented
//   out_data   out  converted value (N bits)
//   out_err    out  Gray-sequence error flag for the presented beat
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high. The source holds in_valid/in_mode/in_data until it is accepted, and
// out_* stay stable while out_valid && !out_ready. Stage k loads whenever it
// is empty or its current beat leaves on the same edge, so bubbles collapse
// and the pipeline sustains one beat per cycle. in_ready is combinational
// from out_ready through that chain; there is no skid buffer.
// -----------------------------------------------------------------------------
module gray_bin_pipe #(
    parameter int N      = 4,
    parameter int STAGES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_mode,
    output logic [N-1:0] out_data,
    output logic         out_err
);

    // Number of G2B bits each stage resolves. The last stage may get fewer,
    // or none at all when STAGES does not divide N evenly.
    localparam int CHUNK = (N + STAGES - 1) / STAGES;

    // Resolves Gray bits hi down to lo of a partly converted word. Bits above
    // hi must already be binary. Bit N-1 never changes because the binary
    // MSB equals the Gray MSB. hi and lo may fall outside 0..N-1 for stages
    // that have nothing left to resolve; those bits are simply skipped.
    function automatic logic [N-1:0] g2b_part(
        input logic [N-1:0] w,
        input int           hi,
        input int           lo
    );
        logic [N-1:0] r;
        r = w;
        for (int i = N - 2; i >= 0; i--) begin
            if ((i <= hi) && (i >= lo)) begin
                r[i] = r[i] ^ r[i+1];
            end
        end
        return r;
    endfunction

    // Per-stage registers
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] m_q;
    logic [STAGES-1:0] e_q;
    logic [N-1:0]      d_q [STAGES];

    // Inputs seen by each stage: stage 0 takes the block input, and stage k
    // takes the register contents of stage k-1.
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_m;
    logic [STAGES-1:0] src_e;
    logic [N-1:0]      src_d [STAGES];
    logic [N-1:0]      nxt_d [STAGES];

    // take[k] = stage k can load this cycle. take[STAGES] is the output
    // port's acceptance. A stage can load if it is empty or if its beat
    // moves on, and it can only move on when the next stage loads.
    logic [STAGES:0]   take;

    // Sequence-error flag attached to the beat being accepted
    logic              seq_err;

    // -------------------------------------------------------------------------
    // Load-enable chain, evaluated from the output back to the input
    // -------------------------------------------------------------------------
    always_comb begin
        take         = '0;
        take[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            take[k] = ~v_q[k] | take[k+1];
        end
    end

    assign in_ready = take[0];

    // -------------------------------------------------------------------------
    // Stage input selection
    // -------------------------------------------------------------------------
    always_comb begin
        src_v = '0;
        src_m = '0;
        src_e = '0;
        for (int k = 0; k < STAGES; k++) begin
            src_d[k] = '0;
        end
        src_v[0] = in_valid;
        src_m[0] = in_mode;
        src_e[0] = seq_err;
        src_d[0] = in_data;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k] = v_q[k-1];
            src_m[k] = m_q[k-1];
            src_e[k] = e_q[k-1];
            src_d[k] = d_q[k-1];
        end
    end

    // -------------------------------------------------------------------------
    // Per-stage conversion work
    //   G2B: resolve this stage's window of the prefix chain, MSB-first.
    //   B2G: stage 0 computes the whole result; later stages pass it through.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            if (!src_m[k]) begin
                nxt_d[k] = g2b_part(src_d[k], N - 1 - k * CHUNK, N - (k + 1) * CHUNK);
            end else if (k == 0) begin
                nxt_d[k] = src_d[k] ^ (src_d[k] >> 1);
            end else begin
                nxt_d[k] = src_d[k];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage registers. A stage that loads while its source is empty becomes
    // empty itself, which is how bubbles are squeezed out. Data, mode and err
    // of an empty stage are don't-care, but they are still cleared on reset
    // so the outputs read zero.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            m_q <= '0;
            e_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (take[k]) begin
                    v_q[k] <= src_v[k];
                    m_q[k] <= src_m[k];
                    e_q[k] <= src_e[k];
                    d_q[k] <= nxt_d[k];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Gray-sequence checker
    // -------------------------------------------------------------------------
`ifdef GRAY_SEQ_CHECK_EN
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] last_g;
    logic         have_last;
    logic [N-1:0] diff;

    // More than one bit set <=> clearing the lowest set bit leaves something.
    // This avoids building a full popcount.
    always_comb begin
        diff = in_data ^ last_g;
    end

    assign seq_err = ~in_mode & have_last & ((diff & (diff - ONE)) != '0);

    // History follows accepted G2B beats only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_g    <= '0;
            have_last <= 1'b0;
        end else if (in_valid && take[0] && !in_mode) begin
            last_g    <= in_data;
            have_last <= 1'b1;
        end
    end
`else
    assign seq_err = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Outputs come directly from the last stage's registers
    // -------------------------------------------------------------------------
    assign out_valid = v_q[STAGES-1];
    assign out_mode  = m_q[STAGES-1];
    assign out_err   = e_q[STAGES-1];
    assign out_data  = d_q[STAGES-1];

endmodule

// File: tb/tb_gray_bin_pipe.sv
// -----------------------------------------------------------------------------
// tb_gray_bin_pipe
//
// Bench for gray_bin_pipe with N=8, STAGES=3 (uneven split: 3/3/2 bits).
// Inputs are driven 1 time unit after a rising edge. Handshakes are sampled
// on the falling edge, where they show what will transfer on the next rising
// edge. The driver pushes the expected result of each accepted beat into
// exp_q, and the monitor pops and compares every beat the DUT hands over.
// The reference model inverts B2G by searching for the binary value whose
// Gray code matches, and it tracks the sequence check with $countones.
// -----------------------------------------------------------------------------
module tb_gray_bin_pipe;

    localparam int N      = 8;
    localparam int STAGES = 3;
`ifdef GRAY_SEQ_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_mode;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_mode;
    logic [N-1:0] out_data;
    logic         out_err;

    gray_bin_pipe #(.N(N), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mode  (out_mode),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- counters / scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    int stalls = 0;

    logic [N+1:0] exp_q[$];       // {mode, err, data}
    logic [N-1:0] last_g    = '0;
    logic         have_last = 1'b0;
    bit           rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [N-1:0] ref_b2g(input logic [N-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray->binary as the inverse of binary->Gray: find the value whose code matches
    function automatic logic [N-1:0] ref_g2b(input logic [N-1:0] g);
        logic [N-1:0] b;
        for (int v = 0; v < (1 << N); v++) begin
            b = v[N-1:0];
            if (ref_b2g(b) == g) return b;
        end
        return '0;
    endfunction

    task automatic push_exp(input logic m, input logic [N-1:0] d);
        logic e;
        logic [N-1:0] r;
        e = 1'b0;
        if (!m) begin
            e         = CHECK_EN && have_last && ($countones(d ^ last_g) > 1);
            last_g    = d;
            have_last = 1'b1;
            r         = ref_g2b(d);
        end else begin
            r = ref_b2g(d);
        end
        exp_q.push_back({m, e, r});
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [N+1:0] ent;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {out_mode, out_err, out_data}, 32'hDEAD);
            end else begin
                ent = exp_q.pop_front();
                check("out_data", out_data, ent[N-1:0]);
                check("out_mode", out_mode, ent[N+1]);
                check("out_err",  out_err,  ent[N]);
            end
        end
    end

    // randomized downstream readiness
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 after the beat is accepted
    task automatic send_beat(input logic m, input logic [N-1:0] d);
        int waitc;
        waitc    = 0;
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                push_exp(m, d);
                break;
            end
            waitc++;
            stalls++;
            if (waitc > 500) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 1000) begin
            @(negedge clk);
            c++;
        end
        check("drain_empty", exp_q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"},  out_data,  0);
        check({tag, "_out_mode"},  out_mode,  0);
        check({tag, "_out_err"},   out_err,   0);
        check({tag, "_in_ready"},  in_ready,  1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [N-1:0] seq_tbl [4];
        logic [N-1:0] d;
        logic         m;
        int           acc;
        int           lat;

        seq_tbl[0] = 8'h00;
        seq_tbl[1] = 8'h01;
        seq_tbl[2] = 8'h01;
        seq_tbl[3] = 8'h07;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency: single beat into an empty pipe with out_ready held high
        out_ready = 1'b1;
        send_beat(1'b0, 8'b0000_0110);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            if (!out_valid) lat++;
        end
        check("latency", lat, STAGES);
        drain();

        // Exhaustive sweep in both modes, back-to-back with out_ready high
        stalls = 0;
        for (int v = 0; v < (1 << N); v++) begin
            d = v[N-1:0];
            send_beat(1'b1, d);
            send_beat(1'b0, d);
        end
        check("sweep_stalls", stalls, 0);
        drain();

        // Backpressure: out_ready low, offer beats for 5 cycles
        out_ready = 1'b0;
        acc = 0;
        d   = N'($urandom);
        m   = 1'($urandom);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_mode  = m;
            in_data  = d;
            @(negedge clk);
            if (in_ready) begin
                push_exp(m, d);
                acc++;
                d = N'($urandom);
                m = 1'($urandom);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("bp_accepted", acc, STAGES);
        @(negedge clk);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        // Full pipe: releasing out_ready must let a new beat in the same cycle
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mode   = 1'b1;
        in_data   = 8'hA5;
        @(negedge clk);
        check("full_accept_and_drain", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // The A5 beat was accepted at that edge
        push_exp(1'b1, 8'hA5);
        drain();

        // Randomized traffic with random downstream stalls
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send_beat(1'($urandom), N'($urandom));
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain();

        // Reset with two beats in flight
        out_ready = 1'b0;
        send_beat(1'b0, 8'h3C);
        send_beat(1'b1, 8'hC3);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        have_last = 1'b0;
        last_g    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_beat(1'b0, 8'h96);
        drain();

        // Gray-sequence check after a fresh reset: 00, 01, 01, 07
        @(negedge clk);
        rst_n = 1'b0;
        have_last = 1'b0;
        last_g    = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            send_beat(1'b0, seq_tbl[i]);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
